// File: rtl/kirby_anim_pkg.sv
// kirby_anim_pkg: action table shared by the animation sequencer and the sprite frame mapper.
package kirby_anim_pkg;

    typedef enum logic [2:0] {
        ACT_IDLE,
        ACT_WALK,
        ACT_INHALE
    } action_t;

    typedef enum logic {
        S_LOOP,
        S_ONESHOT
    } state_t;

    localparam int NUM_ACTIONS = 3;

    localparam logic [3:0] ACT_FRAME_COUNT [0:NUM_ACTIONS-1] = '{4'd2, 4'd10, 4'd10};
    localparam logic       ACT_ONESHOT     [0:NUM_ACTIONS-1] = '{1'b0, 1'b0, 1'b1};

    function automatic logic action_valid(input logic [2:0] a);
        return a < 3'(NUM_ACTIONS);
    endfunction

    // Invalid indices map to a 1-frame, looping entry so callers never see X.
    function automatic logic [3:0] action_frame_count(input logic [2:0] a);
        logic [3:0] r;
        r = 4'd1;
        for (int i = 0; i < NUM_ACTIONS; i++) begin
            if (a == 3'(i)) r = ACT_FRAME_COUNT[i];
        end
        return r;
    endfunction

    function automatic logic action_oneshot(input logic [2:0] a);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_ACTIONS; i++) begin
            if (a == 3'(i)) r = ACT_ONESHOT[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_tick_detect.sv
// frame_tick_detect: synchronizes the asynchronous frame_clk level and emits a
// one-Clk pulse per rising edge (pulse consumed 3 Clk edges after the frame_clk edge).
module frame_tick_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic sync_a;
    logic sync_b;
    logic delayed;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            delayed <= 1'b0;
        end else begin
            sync_a  <= frame_clk;
            sync_b  <= sync_a;
            delayed <= sync_b;
        end
    end

    assign tick = sync_b & ~delayed;

endmodule

// File: rtl/kirby_anim_sequencer.sv
// kirby_anim_sequencer: steps Kirby sprite frames per action at a frame_clk-derived rate.
// Defining KIRBY_ANIM_PAUSE_EN adds a pause input that freezes frame stepping.
module kirby_anim_sequencer
    import kirby_anim_pkg::*;
#(
    parameter int         TICKS_PER_FRAME = 4,
    parameter logic [2:0] RETURN_ACTION   = 3'd0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
`ifdef KIRBY_ANIM_PAUSE_EN
    input  logic       pause,
`endif
    input  logic       req_valid,
    input  logic [2:0] req_action,
    output logic       req_ready,
    output logic [2:0] character_action_idx,
    output logic [3:0] character_action_frame_idx,
    output logic       anim_done,
    output logic       busy
);

    localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_FRAME - 1);

    state_t     state;
    state_t     state_next;
    logic [2:0] action_next;
    logic [3:0] frame_next;
    logic [3:0] frame_last;
    logic [3:0] tick_cnt;
    logic [3:0] tick_cnt_next;
    logic       anim_done_next;
    logic       tick;
    logic       tick_en;
    logic       accept;

    frame_tick_detect u_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

`ifdef KIRBY_ANIM_PAUSE_EN
    assign tick_en = tick & ~pause;
`else
    assign tick_en = tick;
`endif

    // Handshake: a request transfers on any Clk edge where req_valid and req_ready
    // are both high; req_ready is low only while a one-shot plays.
    assign req_ready  = (state == S_LOOP);
    assign busy       = (state == S_ONESHOT);
    assign accept     = req_valid & req_ready;
    assign frame_last = action_frame_count(character_action_idx) - 4'd1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state                      <= S_LOOP;
            character_action_idx       <= 3'd0;
            character_action_frame_idx <= 4'd0;
            tick_cnt                   <= 4'd0;
            anim_done                  <= 1'b0;
        end else begin
            state                      <= state_next;
            character_action_idx       <= action_next;
            character_action_frame_idx <= frame_next;
            tick_cnt                   <= tick_cnt_next;
            anim_done                  <= anim_done_next;
        end
    end

    always_comb begin
        state_next     = state;
        action_next    = character_action_idx;
        frame_next     = character_action_frame_idx;
        tick_cnt_next  = tick_cnt;
        anim_done_next = 1'b0;
        // An accepted request swallows a coincident tick; same-action and
        // invalid requests are acknowledged without disturbing playback.
        if (accept) begin
            if (action_valid(req_action) && (req_action != character_action_idx)) begin
                action_next   = req_action;
                frame_next    = 4'd0;
                tick_cnt_next = 4'd0;
                state_next    = action_oneshot(req_action) ? S_ONESHOT : S_LOOP;
            end
        end else if (tick_en) begin
            if (tick_cnt == TICK_LAST) begin
                tick_cnt_next = 4'd0;
                if (character_action_frame_idx == frame_last) begin
                    frame_next = 4'd0;
                    if (state == S_ONESHOT) begin
                        action_next    = RETURN_ACTION;
                        state_next     = S_LOOP;
                        anim_done_next = 1'b1;
                    end
                end else begin
                    frame_next = character_action_frame_idx + 4'd1;
                end
            end else begin
                tick_cnt_next = tick_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_kirby_anim_sequencer.sv
// tb_kirby_anim_sequencer: randomized frame_clk/request stimulus checked cycle by cycle
// against an action-table reference model through an expected-output queue.
module tb_kirby_anim_sequencer;

    localparam int TPF = 4;
    localparam int RET = 0;
    localparam int EW  = 10;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       pause;
    logic       req_valid;
    logic [2:0] req_action;
    logic       req_ready;
    logic [2:0] character_action_idx;
    logic [3:0] character_action_frame_idx;
    logic       anim_done;
    logic       busy;

    kirby_anim_sequencer #(.TICKS_PER_FRAME(TPF), .RETURN_ACTION(3'(RET))) dut (
        .Clk                        (Clk),
        .Reset                      (Reset),
        .frame_clk                  (frame_clk),
`ifdef KIRBY_ANIM_PAUSE_EN
        .pause                      (pause),
`endif
        .req_valid                  (req_valid),
        .req_action                 (req_action),
        .req_ready                  (req_ready),
        .character_action_idx       (character_action_idx),
        .character_action_frame_idx (character_action_frame_idx),
        .anim_done                  (anim_done),
        .busy                       (busy)
    );

    // clock / reset
    always #5 Clk = ~Clk;

    // reference model state
    int frame_count_tab [3] = '{2, 10, 10};
    bit oneshot_tab     [3] = '{0, 0, 1};
    int m_act, m_frame, m_ticks;
    bit m_oneshot, m_done, m_accepted;
    bit hist [4];

    logic [EW-1:0] exp_q [$];
    int errors = 0;
    int checks = 0;

    bit fclk = 0;
    int fc_cnt = 3;
    int edges = 0;
    bit cur_v = 0;
    int cur_a = 0;
    int done_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Frame_clk history: hist[i] is the level sampled at the Clk edge i edges ago.
    task automatic model_step(input bit rst, input bit v, input int a, input bit f, input bit p);
        bit t;
        hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = f;
        m_accepted = 0;
        m_done = 0;
        if (rst) begin
            for (int i = 0; i < 4; i++) hist[i] = 0;
            m_act = 0; m_frame = 0; m_ticks = 0; m_oneshot = 0;
            return;
        end
        t = hist[2] & ~hist[3] & ~p;
        if (v && !m_oneshot) begin
            m_accepted = 1;
            if (a < 3 && a != m_act) begin
                m_act = a; m_frame = 0; m_ticks = 0; m_oneshot = oneshot_tab[a];
            end
        end else if (t) begin
            m_ticks++;
            if (m_ticks == TPF) begin
                m_ticks = 0;
                m_frame++;
                if (m_frame == frame_count_tab[m_act]) begin
                    m_frame = 0;
                    if (m_oneshot) begin
                        m_act = RET; m_oneshot = 0; m_done = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("action_idx", 32'(character_action_idx), 32'(e[9:7]));
            check("frame_idx", 32'(character_action_frame_idx), 32'(e[6:3]));
            check("anim_done", 32'(anim_done), 32'(e[2]));
            check("busy", 32'(busy), 32'(e[1]));
            check("req_ready", 32'(req_ready), 32'(e[0]));
            if (anim_done === 1'b1) done_seen++;
        end
    endtask

    // driver: one Clk cycle; outputs checked on the falling edge, inputs driven there too
    task automatic cycle(input bit rst, input bit v, input int a, input bit p);
        @(negedge Clk);
        check_outputs();
        if (fc_cnt == 0) begin
            fclk = ~fclk;
            fc_cnt = $urandom_range(2, 5);
            if (fclk) edges++;
        end else begin
            fc_cnt--;
        end
        Reset = rst;
        req_valid = v;
        req_action = 3'(a);
        pause = p;
        frame_clk = fclk;
        model_step(rst, v, a, fclk, p);
        exp_q.push_back({3'(m_act), 4'(m_frame), m_done, m_oneshot, ~m_oneshot});
    endtask

    // Runs for n rising frame_clk edges; a request (if any) is held until accepted.
    task automatic run_edges(input int n, input bit v, input int a, input bit p);
        int target;
        bit vv;
        target = edges + n;
        vv = v;
        while (edges < target) begin
            cycle(0, vv, a, p);
            if (m_accepted) vv = 0;
        end
        repeat (4) cycle(0, 0, 0, 0);
    endtask

    initial begin
        int guard;
        int done_before;
        Reset = 1; frame_clk = 0; pause = 0; req_valid = 0; req_action = 0;
        cycle(1, 1, 1, 0);
        cycle(1, 1, 2, 0);
        cycle(1, 0, 0, 0);

        // idle loop across 9 edges, then walk for 40+ ticks
        run_edges(9, 0, 0, 0);
        run_edges(44, 1, 1, 0);

        // inhale one-shot with a walk request held throughout
        done_before = done_seen;
        run_edges(1, 1, 2, 0);
        run_edges(46, 1, 1, 0);
        check("done_pulse_count", 32'(done_seen - done_before), 32'd1);
        check("walk_after_inhale", 32'(character_action_idx), 32'd1);

        // accept landing on the same edge as the frame-advancing tick
        for (int k = 0; k < 3; k++) begin
            guard = 0;
            while (!(hist[1] && !hist[2] && m_ticks == TPF - 1 && !m_oneshot) && guard < 300) begin
                cycle(0, 0, 0, 0);
                guard++;
            end
            check("sync_wait_bound", 32'(guard < 300), 32'd1);
            cycle(0, 1, (m_act == 0) ? 1 : 0, 0);
            run_edges(6, 0, 0, 0);
        end

        // invalid and same-action requests
        run_edges(3, 1, 5, 0);
        run_edges(3, 1, 7, 0);
        run_edges(3, 1, m_act, 0);

        // reset in the middle of a one-shot, with a request during reset
        run_edges(1, 1, 2, 0);
        run_edges(8, 0, 0, 0);
        done_before = done_seen;
        cycle(1, 1, 1, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("no_done_after_reset", 32'(done_seen - done_before), 32'd0);

`ifdef KIRBY_ANIM_PAUSE_EN
        run_edges(1, 1, 1, 0);
        run_edges(8, 0, 0, 1);
        run_edges(4, 1, 0, 1);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit p;
            p = 0;
`ifdef KIRBY_ANIM_PAUSE_EN
            p = ($urandom_range(0, 7) == 0);
`endif
            if (!cur_v && $urandom_range(0, 9) == 0) begin
                cur_v = 1;
                cur_a = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 7) : $urandom_range(0, 2);
            end
            cycle((i % 997) == 500, cur_v, cur_a, p);
            if (m_accepted || Reset) cur_v = 0;
        end
        repeat (2) cycle(0, 0, 0, 0);
        @(negedge Clk);
        check_outputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
